// File: rtl/disp_pkg.sv
// Shared types and helpers for the shared 7-segment display arbiter.
package disp_pkg;

  localparam int DATA_W    = 10;
  localparam int DIGIT_MAX = 999;

  typedef enum logic [1:0] {IDLE, SHOW, GAP} disp_state_t;

  // The display has only three digits, so anything larger saturates.
  function automatic logic [DATA_W-1:0] clamp999(input logic [DATA_W-1:0] v);
    return (v > DATA_W'(DIGIT_MAX)) ? DATA_W'(DIGIT_MAX) : v;
  endfunction

endpackage

// File: rtl/disp_rr_pick.sv
// Combinational round-robin picker: first set request after the last owner.
module disp_rr_pick
  import disp_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] sel,
  output logic             found
);

  int idx;

  // Scan from farthest to nearest so the nearest requester after last wins.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (req[idx]) begin
        sel   = IDX_W'(idx);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/disp_share_arb.sv
// Round-robin owner of one 3-digit display with HOLD windows and GAP blanks.
// Define DISP_PRIO_EN to make requester 0 urgent (always wins, preempts others).
module disp_share_arb
  import disp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int HOLD = 1000,
  parameter int GAP  = 50
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] val,
  output logic [NREQ-1:0]        gnt,
  output logic [DATA_W-1:0]      data,
  output logic                   blank,
  output logic                   busy
);

  localparam int IDX_W   = $clog2(NREQ);
  localparam int CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP - 1);

  disp_state_t       state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              blank_q, blank_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  last_q, last_d;

  logic [IDX_W-1:0]  pick_sel, win_sel;
  logic              pick_found, win_found;
  logic              preempt;
  logic              others_pending;

  disp_rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req   (req),
    .last  (last_q),
    .sel   (pick_sel),
    .found (pick_found)
  );

`ifdef DISP_PRIO_EN
  assign win_sel   = req[0] ? '0 : pick_sel;
  assign win_found = pick_found;
  assign preempt   = req[0] && (last_q != '0);
`else
  assign win_sel   = pick_sel;
  assign win_found = pick_found;
  assign preempt   = 1'b0;
`endif

  // In SHOW gnt_q is onehot(last_q), so masking it leaves the other requesters.
  assign others_pending = |(req & ~gnt_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    blank_d = blank_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = SHOW;
          gnt_d   = NREQ'(1) << win_sel;
          data_d  = clamp999(val[int'(win_sel)*DATA_W +: DATA_W]);
          blank_d = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = HOLD_LD;
          last_d  = win_sel;
        end
      end
      SHOW: begin
        data_d = clamp999(val[int'(last_q)*DATA_W +: DATA_W]);
        if (!req[last_q] || preempt || (cnt_q == '0 && others_pending)) begin
          state_d = disp_pkg::GAP;
          gnt_d   = '0;
          data_d  = '0;
          blank_d = 1'b1;
          cnt_d   = GAP_LD;
        end else if (cnt_q == '0) begin
          cnt_d = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      disp_pkg::GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        data_d  = '0;
        blank_d = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      data_q  <= '0;
      blank_q <= 1'b1;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      last_q  <= IDX_W'(NREQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      blank_q <= blank_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign gnt   = gnt_q;
  assign data  = data_q;
  assign blank = blank_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_disp_share_arb.sv
// Scoreboard bench for disp_share_arb (NREQ=4, HOLD=4, GAP=2).
module tb_disp_share_arb;

  localparam int NREQ = 4;
  localparam int HOLD = 4;
  localparam int GAP  = 2;

  typedef struct packed {
    logic [3:0] gnt;
    logic [9:0] data;
    logic       blank;
    logic       busy;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic [3:0]  req;
  logic [39:0] val;
  logic [3:0]  gnt;
  logic [9:0]  data;
  logic        blank;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  exp_t exp_q[$];
  logic [3:0] order_q[$];
  logic [3:0] prev_gnt;
  bit   track_order;
  int   blank_seen;

  int         m_state;
  int         m_cnt;
  int         m_last;
  logic [3:0] m_gnt;
  logic [9:0] m_data;
  logic       m_blank;
  logic       m_busy;

  disp_share_arb #(.NREQ(NREQ), .HOLD(HOLD), .GAP(GAP)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .req   (req),
    .val   (val),
    .gnt   (gnt),
    .data  (data),
    .blank (blank),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic int clampv(input int v);
    return (v > 999) ? 999 : v;
  endfunction

  function automatic int val_of(input int i);
    return int'(val[i*10 +: 10]);
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_cnt   = 0;
    m_last  = NREQ - 1;
    m_gnt   = 4'b0000;
    m_data  = 10'd0;
    m_blank = 1'b1;
    m_busy  = 1'b0;
  endtask

  // Reference behaviour: predicts the registered outputs after the next edge.
  task automatic model_step();
    int   owner;
    int   idx;
    bit   leave;
    exp_t e;
    case (m_state)
      0: begin
        owner = -1;
`ifdef DISP_PRIO_EN
        if (req[0]) owner = 0;
`endif
        for (int k = 1; k <= NREQ; k++) begin
          idx = (m_last + k) % NREQ;
          if (owner < 0 && req[idx]) owner = idx;
        end
        if (owner >= 0) begin
          m_state = 1;
          m_last  = owner;
          m_cnt   = HOLD - 1;
          m_gnt   = 4'(1 << owner);
          m_data  = 10'(clampv(val_of(owner)));
          m_blank = 1'b0;
          m_busy  = 1'b1;
        end
      end
      1: begin
        m_data = 10'(clampv(val_of(m_last)));
        leave  = !req[m_last] || (m_cnt == 0 && (req & ~m_gnt) != 4'b0000);
`ifdef DISP_PRIO_EN
        if (m_last != 0 && req[0]) leave = 1'b1;
`endif
        if (leave) begin
          m_state = 2;
          m_cnt   = GAP - 1;
          m_gnt   = 4'b0000;
          m_data  = 10'd0;
          m_blank = 1'b1;
        end else begin
          m_cnt = (m_cnt == 0) ? HOLD - 1 : m_cnt - 1;
        end
      end
      default: begin
        if (m_cnt == 0) begin
          m_state = 0;
          m_busy  = 1'b0;
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
    endcase
    e.gnt   = m_gnt;
    e.data  = m_data;
    e.blank = m_blank;
    e.busy  = m_busy;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checkOutput("gnt", 32'(gnt), 32'(e.gnt));
    checkOutput("data", 32'(data), 32'(e.data));
    checkOutput("blank", 32'(blank), 32'(e.blank));
    checkOutput("busy", 32'(busy), 32'(e.busy));
    if (blank) blank_seen++;
    if (track_order && gnt != 4'b0000 && prev_gnt == 4'b0000) order_q.push_back(gnt);
    prev_gnt = gnt;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [39:0] v, input int n);
    req = r;
    val = v;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic applyReset();
    rstn = 1'b0;
    #1;
    model_reset();
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_data", 32'(data), 32'd0);
    checkOutput("rst_blank", 32'(blank), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    #2;
    rstn = 1'b1;
    prev_gnt = 4'b0000;
  endtask

  initial begin
    rstn = 1'b1;
    req  = 4'b0000;
    val  = 40'd0;
    prev_gnt    = 4'b0000;
    track_order = 1'b0;
    blank_seen  = 0;
    @(posedge clk);
    #1;
    applyReset();

    // Reset in the middle of a SHOW window, then a lone req[3] wins.
    applyStimulus(4'b1111, {10'd300, 10'd200, 10'd100, 10'd0}, 2);
    checkOutput("mid_show_busy", 32'(busy), 32'd1);
    applyReset();
    applyStimulus(4'b1000, {10'd7, 10'd200, 10'd100, 10'd0}, 1);
    checkOutput("first_after_reset", 32'(gnt), 32'b1000);
    applyStimulus(4'b1000, {10'd7, 10'd200, 10'd100, 10'd0}, 2);

    // Full round-robin rotation.
    applyReset();
    track_order = 1'b1;
    order_q.delete();
    applyStimulus(4'b1111, {10'd300, 10'd200, 10'd100, 10'd0}, 36);
    track_order = 1'b0;
    checkOutput("rr_count", 32'(order_q.size() >= 5), 32'd1);
    if (order_q.size() >= 5) begin
      checkOutput("rr_0", 32'(order_q[0]), 32'b0001);
      checkOutput("rr_1", 32'(order_q[1]), 32'b0010);
      checkOutput("rr_2", 32'(order_q[2]), 32'b0100);
      checkOutput("rr_3", 32'(order_q[3]), 32'b1000);
      checkOutput("rr_4", 32'(order_q[4]), 32'b0001);
    end

    // Single owner holds the display across several windows without blanking.
    req = 4'b0100;
    val = {10'd0, 10'd123, 10'd0, 10'd0};
    for (int i = 0; i < 20 && m_gnt != 4'b0100; i++) tick();
    checkOutput("single_granted", 32'(m_gnt), 32'b0100);
    blank_seen = 0;
    applyStimulus(4'b0100, {10'd0, 10'd123, 10'd0, 10'd0}, 14);
    checkOutput("single_no_blank", 32'(blank_seen), 32'd0);

    // Clamp and early release on the second SHOW cycle.
    req = 4'b0000;
    for (int i = 0; i < 20 && m_state != 0; i++) tick();
    checkOutput("idle_reached", 32'(m_state), 32'd0);
    applyStimulus(4'b0001, {10'd0, 10'd0, 10'd0, 10'd1023}, 1);
    checkOutput("clamp", 32'(data), 32'd999);
    applyStimulus(4'b0001, {10'd0, 10'd0, 10'd0, 10'd1023}, 1);
    applyStimulus(4'b0000, {10'd0, 10'd0, 10'd0, 10'd1023}, 1);
    checkOutput("early_release_blank", 32'(blank), 32'd1);
    applyStimulus(4'b0000, 40'd0, 3);

    // Request raised during GAP waits; data tracks a live-changing value.
    req = 4'b0010;
    val = {10'd0, 10'd0, 10'd55, 10'd0};
    for (int i = 0; i < 20 && m_state != 1; i++) tick();
    checkOutput("show_reached", 32'(m_state), 32'd1);
    applyStimulus(4'b0000, val, 1);
    for (int i = 0; i < 8; i++)
      applyStimulus(4'b0100, {10'd0, 10'(300 + 7 * i), 10'd55, 10'd0}, 1);

    // Requester 0 arrives while requester 1 owns the display.
    req = 4'b0010;
    val = {10'd0, 10'd0, 10'd11, 10'd22};
    for (int i = 0; i < 20 && m_gnt != 4'b0010; i++) tick();
    checkOutput("owner1_granted", 32'(m_gnt), 32'b0010);
    applyStimulus(4'b0011, val, 1);
`ifdef DISP_PRIO_EN
    checkOutput("preempt_blank", 32'(blank), 32'd1);
`else
    checkOutput("no_preempt_gnt", 32'(gnt), 32'b0010);
`endif
    applyStimulus(4'b0011, val, 8);

    // Random traffic.
    for (int i = 0; i < 60; i++)
      applyStimulus(4'($urandom_range(0, 15)),
                    {10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom)}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
